// File: rtl/zeroheti_edf_sched.sv
// Earliest-deadline-first interrupt scheduler: per-line relative deadlines, edge stamping, and
// a registered min-slack arbiter. Optional miss counter under ZEROHETI_EDF_MISS_CNT_EN.
module zeroheti_edf_sched #(
    parameter int unsigned NrIrqs    = 32,
    parameter int unsigned TimeWidth = 16,
    localparam int unsigned IrqWidth = $clog2(NrIrqs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NrIrqs-1:0]    ext_irqs_i,
    input  logic                 cfg_we_i,
    input  logic [IrqWidth-1:0]  cfg_idx_i,
    input  logic                 cfg_en_i,
    input  logic [TimeWidth-1:0] cfg_dl_i,
    output logic                 irq_valid_o,
    output logic [IrqWidth-1:0]  irq_id_o,
    input  logic                 irq_ack_i,
    input  logic [IrqWidth-1:0]  irq_id_i,
    output logic [TimeWidth-1:0] time_o,
    output logic                 miss_o,
    output logic [15:0]          miss_cnt_o
);

    localparam int unsigned NrLeaves = 2 ** IrqWidth;
    localparam int unsigned NrNodes  = 2 * NrLeaves - 1;

    logic [NrIrqs-1:0]    en_q, en_d, pend_q, pend_d, prev_q;
    logic [TimeWidth-1:0] rel_dl_q [NrIrqs];
    logic [TimeWidth-1:0] rel_dl_d [NrIrqs];
    logic [TimeWidth-1:0] abs_dl_q [NrIrqs];
    logic [TimeWidth-1:0] abs_dl_d [NrIrqs];
    logic [TimeWidth-1:0] now_q;
    logic                 irq_valid_q, irq_valid_d;
    logic [IrqWidth-1:0]  irq_id_q, irq_id_d;

    logic [NrIrqs-1:0] rise, ack_hit, cand;

    always_comb begin
        rise = ext_irqs_i & ~prev_q;
        for (int unsigned i = 0; i < NrIrqs; i++) begin
            ack_hit[i] = irq_ack_i && (irq_id_i == IrqWidth'(i));
        end
        // An acked line drops out immediately so it is never re-offered the next cycle.
        cand = pend_q & en_q & ~ack_hit;
    end

    always_comb begin
        en_d     = en_q;
        pend_d   = pend_q;
        rel_dl_d = rel_dl_q;
        abs_dl_d = abs_dl_q;
        if (cfg_we_i && (32'(cfg_idx_i) < NrIrqs)) begin
            en_d[cfg_idx_i]     = cfg_en_i;
            rel_dl_d[cfg_idx_i] = cfg_dl_i;
        end
        for (int unsigned i = 0; i < NrIrqs; i++) begin
            // A new edge takes priority over a same-cycle ack and re-stamps the deadline.
            if (rise[i]) begin
                pend_d[i]   = 1'b1;
                abs_dl_d[i] = now_q + rel_dl_q[i];
            end else if (ack_hit[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin : arb
        logic                        nd_vld   [NrNodes];
        logic signed [TimeWidth-1:0] nd_slack [NrNodes];
        logic [IrqWidth-1:0]         nd_id    [NrNodes];
        for (int unsigned n = 0; n < NrNodes; n++) begin
            nd_vld[n]   = 1'b0;
            nd_slack[n] = '0;
            nd_id[n]    = '0;
        end
        for (int unsigned i = 0; i < NrLeaves; i++) begin
            if (i < NrIrqs) begin
                nd_vld[NrLeaves-1+i]   = cand[i];
                nd_slack[NrLeaves-1+i] = abs_dl_q[i] - now_q;
                nd_id[NrLeaves-1+i]    = IrqWidth'(i);
            end
        end
        // Left subtree always holds lower ids, so it wins on equal slack.
        for (int n = int'(NrLeaves) - 2; n >= 0; n--) begin
            if (nd_vld[2*n+1] && (!nd_vld[2*n+2] || (nd_slack[2*n+1] <= nd_slack[2*n+2]))) begin
                nd_slack[n] = nd_slack[2*n+1];
                nd_id[n]    = nd_id[2*n+1];
            end else begin
                nd_slack[n] = nd_slack[2*n+2];
                nd_id[n]    = nd_id[2*n+2];
            end
            nd_vld[n] = nd_vld[2*n+1] | nd_vld[2*n+2];
        end
        irq_valid_d = nd_vld[0];
        irq_id_d    = nd_vld[0] ? nd_id[0] : irq_id_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q        <= '0;
            pend_q      <= '0;
            prev_q      <= '0;
            rel_dl_q    <= '{default: '0};
            abs_dl_q    <= '{default: '0};
            now_q       <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            en_q        <= en_d;
            pend_q      <= pend_d;
            prev_q      <= ext_irqs_i;
            rel_dl_q    <= rel_dl_d;
            abs_dl_q    <= abs_dl_d;
            now_q       <= now_q + 1'b1;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
        end
    end

    assign irq_valid_o = irq_valid_q;
    assign irq_id_o    = irq_id_q;
    assign time_o      = now_q;

`ifdef ZEROHETI_EDF_MISS_CNT_EN
    logic        miss_q, miss_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        miss_d = 1'b0;
        for (int unsigned i = 0; i < NrIrqs; i++) begin
            if (cand[i] && (abs_dl_q[i] == now_q)) begin
                miss_d = 1'b1;
            end
        end
        miss_cnt_d = miss_cnt_q;
        if (miss_d && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_q     <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            miss_q     <= miss_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_o     = miss_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign miss_o     = 1'b0;
    assign miss_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_zeroheti_edf_sched.sv
// Self-checking bench for zeroheti_edf_sched: directed scenarios plus randomized traffic
// checked against a slack-ordered reference model.
module tb_zeroheti_edf_sched;

    localparam int N = 32;
`ifdef ZEROHETI_EDF_MISS_CNT_EN
    localparam bit MissEn = 1'b1;
`else
    localparam bit MissEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] ext_irqs = '0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_dl = '0;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic        irq_ack = 1'b0;
    logic [4:0]  ack_id = '0;
    logic [15:0] time_o;
    logic        miss;
    logic [15:0] miss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    zeroheti_edf_sched dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .ext_irqs_i (ext_irqs),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_en_i   (cfg_en),
        .cfg_dl_i   (cfg_dl),
        .irq_valid_o(irq_valid),
        .irq_id_o   (irq_id),
        .irq_ack_i  (irq_ack),
        .irq_id_i   (ack_id),
        .time_o     (time_o),
        .miss_o     (miss),
        .miss_cnt_o (miss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_en[N];
    int m_rel[N];
    bit m_pend[N];
    int m_abs[N];
    bit m_prev[N];
    int m_now;
    bit m_valid;
    int m_id;
    bit m_miss;
    int m_cnt;

    function automatic int slack_of(int i);
        int d;
        d = (m_abs[i] - m_now + 65536) % 65536;
        if (d >= 32768) d -= 65536;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_rel[i] = 0; m_pend[i] = 0; m_abs[i] = 0; m_prev[i] = 0;
        end
        m_now = 0; m_valid = 0; m_id = 0; m_miss = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int  best;
        int  bs;
        bit  any_miss;
        bit  acked;
        best = -1; bs = 0; any_miss = 0;
        for (int i = 0; i < N; i++) begin
            acked = irq_ack && (int'(ack_id) == i);
            if (m_pend[i] && m_en[i] && !acked) begin
                if (best < 0 || slack_of(i) < bs) begin
                    best = i;
                    bs = slack_of(i);
                end
                if (m_abs[i] == m_now) any_miss = 1;
            end
        end
        m_valid = (best >= 0);
        if (best >= 0) m_id = best;
        m_miss = any_miss;
        if (any_miss && m_cnt < 65535) m_cnt++;
        for (int i = 0; i < N; i++) begin
            acked = irq_ack && (int'(ack_id) == i);
            if (ext_irqs[i] && !m_prev[i]) begin
                m_pend[i] = 1;
                m_abs[i] = (m_now + m_rel[i]) % 65536;
            end else if (acked) begin
                m_pend[i] = 0;
            end
            m_prev[i] = ext_irqs[i];
        end
        if (cfg_we) begin
            m_en[cfg_idx] = cfg_en;
            m_rel[cfg_idx] = int'(cfg_dl);
        end
        m_now = (m_now + 1) % 65536;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ext_irqs = '0; cfg_we = 0; irq_ack = 0;
        rst_ni = 0;
        #2;
        rst_ni = 1;
        model_reset();
    endtask

    task automatic cfg(input int idx, input bit en, input int dl);
        cfg_we = 1; cfg_idx = 5'(idx); cfg_en = en; cfg_dl = 16'(dl);
        step();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        irq_ack = 1; ack_id = 5'd3;
        #1;
        n_cmp++;
        if (irq_valid !== 1'b0 || irq_id !== 5'd0 || time_o !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%0b id=%0d time=%0d, want 0/0/0", irq_valid, irq_id,
                     time_o);
        end
        n_cmp++;
        if (miss !== 1'b0 || miss_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_miss: miss=%0b cnt=%0d, want 0/0", miss, miss_cnt);
        end
        @(posedge clk); @(posedge clk); #1;
        n_cmp++;
        if (irq_valid !== 1'b0 || time_o !== 16'd0) begin
            n_err++;
            $display("FAIL reset_held: valid=%0b time=%0d, want 0/0", irq_valid, time_o);
        end
        irq_ack = 0;
        rst_ni = 1;
        model_reset();
        step();
        n_cmp++;
        if (time_o !== 16'd1 || irq_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: time=%0d valid=%0b, want 1/0", time_o, irq_valid);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cfg(3, 1, 10);
        while (m_now != 5) step();
        ext_irqs[3] = 1;
        step();
        n_cmp++;
        if (irq_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_latency: valid=%0b one cycle after edge, want 0", irq_valid);
        end
        step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd3) begin
            n_err++;
            $display("FAIL basic_offer: valid=%0b id=%0d, want 1/3", irq_valid, irq_id);
        end
        irq_ack = 1; ack_id = 5'd3;
        step();
        irq_ack = 0;
        n_cmp++;
        if (irq_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ack: valid=%0b, want 0", irq_valid);
        end
    endtask

    task automatic test_two_lines();
        do_reset();
        cfg(1, 1, 40);
        cfg(7, 1, 8);
        ext_irqs[1] = 1; ext_irqs[7] = 1;
        step(); step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd7) begin
            n_err++;
            $display("FAIL two_first: valid=%0b id=%0d, want 1/7", irq_valid, irq_id);
        end
        irq_ack = 1; ack_id = 5'd7;
        step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd1) begin
            n_err++;
            $display("FAIL two_second: valid=%0b id=%0d, want 1/1", irq_valid, irq_id);
        end
        ack_id = 5'd1;
        step();
        irq_ack = 0;
        n_cmp++;
        if (irq_valid !== 1'b0) begin
            n_err++;
            $display("FAIL two_drain: valid=%0b, want 0", irq_valid);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        cfg(2, 1, 50);
        cfg(9, 1, 5);
        ext_irqs[2] = 1;
        step(); step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd2) begin
            n_err++;
            $display("FAIL preempt_before: valid=%0b id=%0d, want 1/2", irq_valid, irq_id);
        end
        ext_irqs[9] = 1;
        step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd2) begin
            n_err++;
            $display("FAIL preempt_hold: valid=%0b id=%0d, want 1/2", irq_valid, irq_id);
        end
        step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd9) begin
            n_err++;
            $display("FAIL preempt_switch: valid=%0b id=%0d, want 1/9", irq_valid, irq_id);
        end
    endtask

    task automatic test_tie_and_reedge();
        do_reset();
        cfg(6, 1, 12);
        cfg(2, 1, 12);
        ext_irqs[6] = 1; ext_irqs[2] = 1;
        step(); step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd2) begin
            n_err++;
            $display("FAIL tie_low_id: valid=%0b id=%0d, want 1/2", irq_valid, irq_id);
        end
        irq_ack = 1; ack_id = 5'd2;
        step();
        ack_id = 5'd6;
        step();
        irq_ack = 0;
        ext_irqs = '0;
        cfg(5, 1, 100);
        cfg(8, 1, 95);
        ext_irqs[5] = 1;
        step();
        ext_irqs[5] = 0;
        repeat (9) step();
        ext_irqs[5] = 1; irq_ack = 1; ack_id = 5'd5;
        step();
        irq_ack = 0;
        n_cmp++;
        if (irq_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ack_edge_not_reoffered: valid=%0b, want 0", irq_valid);
        end
        ext_irqs[8] = 1;
        step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd5) begin
            n_err++;
            $display("FAIL ack_edge_pending: valid=%0b id=%0d, want 1/5", irq_valid, irq_id);
        end
        step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd8) begin
            n_err++;
            $display("FAIL ack_edge_restamp: valid=%0b id=%0d, want 1/8", irq_valid, irq_id);
        end
    endtask

    task automatic test_disable();
        do_reset();
        cfg(10, 1, 20);
        ext_irqs[10] = 1;
        step(); step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd10) begin
            n_err++;
            $display("FAIL disable_pre: valid=%0b id=%0d, want 1/10", irq_valid, irq_id);
        end
        cfg(10, 0, 20);
        n_cmp++;
        if (irq_valid !== 1'b1) begin
            n_err++;
            $display("FAIL disable_write_cycle: valid=%0b, want 1", irq_valid);
        end
        step();
        n_cmp++;
        if (irq_valid !== 1'b0) begin
            n_err++;
            $display("FAIL disable_removed: valid=%0b, want 0", irq_valid);
        end
        cfg(10, 1, 20);
        step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd10) begin
            n_err++;
            $display("FAIL disable_kept_pend: valid=%0b id=%0d, want 1/10", irq_valid, irq_id);
        end
    endtask

    task automatic test_miss();
        do_reset();
        cfg(0, 1, 3);
        ext_irqs[0] = 1;
        step(); step(); step();
        n_cmp++;
        if (miss !== 1'b0) begin
            n_err++;
            $display("FAIL miss_early: miss=%0b, want 0", miss);
        end
        step();
        n_cmp++;
        if (miss !== MissEn || miss_cnt !== 16'(MissEn)) begin
            n_err++;
            $display("FAIL miss_pulse: miss=%0b cnt=%0d, want %0b/%0d", miss, miss_cnt, MissEn,
                     MissEn);
        end
        step();
        n_cmp++;
        if (miss !== 1'b0 || miss_cnt !== 16'(MissEn) || irq_valid !== 1'b1 || irq_id !== 5'd0)
        begin
            n_err++;
            $display("FAIL miss_after: miss=%0b cnt=%0d valid=%0b id=%0d, want 0/%0d/1/0", miss,
                     miss_cnt, irq_valid, irq_id, MissEn);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N; i++) cfg(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 60));
        for (int c = 0; c < 3000; c++) begin
            ext_irqs = ext_irqs ^ ($urandom & $urandom & $urandom);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_idx = 5'($urandom_range(0, 31));
            cfg_en = 1'($urandom_range(0, 3) != 0);
            cfg_dl = 16'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 32767)
                                                     : $urandom_range(0, 60));
            irq_ack = ($urandom_range(0, 2) == 0);
            ack_id = ($urandom_range(0, 1) == 0) ? 5'(m_id) : 5'($urandom_range(0, 31));
            step();
            n_cmp++;
            if (irq_valid !== m_valid || irq_id !== 5'(m_id)) begin
                n_err++;
                $display("FAIL rand_offer c=%0d: valid=%0b id=%0d, want %0b/%0d", c, irq_valid,
                         irq_id, m_valid, m_id);
            end
            n_cmp++;
            if (time_o !== 16'(m_now)) begin
                n_err++;
                $display("FAIL rand_time c=%0d: time=%0d, want %0d", c, time_o, m_now);
            end
            n_cmp++;
            if (miss !== (MissEn & m_miss) || miss_cnt !== (MissEn ? 16'(m_cnt) : 16'd0)) begin
                n_err++;
                $display("FAIL rand_miss c=%0d: miss=%0b cnt=%0d, want %0b/%0d", c, miss,
                         miss_cnt, MissEn & m_miss, MissEn ? m_cnt : 0);
            end
        end
        cfg_we = 0; irq_ack = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        cfg(4, 1, 20);
        cfg(5, 1, 30);
        while (m_now != 16'hFFF0) step();
        ext_irqs[4] = 1;
        step();
        while (m_now != 16'hFFF5) step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd4) begin
            n_err++;
            $display("FAIL wrap_first: valid=%0b id=%0d, want 1/4", irq_valid, irq_id);
        end
        ext_irqs[5] = 1;
        step(); step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd4 || time_o !== 16'hFFF7) begin
            n_err++;
            $display("FAIL wrap_order: valid=%0b id=%0d time=%h, want 1/4/fff7", irq_valid,
                     irq_id, time_o);
        end
        irq_ack = 1; ack_id = 5'd4;
        step();
        irq_ack = 0;
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd5) begin
            n_err++;
            $display("FAIL wrap_next: valid=%0b id=%0d, want 1/5", irq_valid, irq_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg(11, 1, 30);
        ext_irqs[11] = 1;
        step(); step();
        n_cmp++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd11) begin
            n_err++;
            $display("FAIL areset_pre: valid=%0b id=%0d, want 1/11", irq_valid, irq_id);
        end
        #2;
        rst_ni = 0;
        #1;
        n_cmp++;
        if (irq_valid !== 1'b0 || irq_id !== 5'd0 || time_o !== 16'd0) begin
            n_err++;
            $display("FAIL areset_immediate: valid=%0b id=%0d time=%0d, want 0/0/0", irq_valid,
                     irq_id, time_o);
        end
        ext_irqs = '0;
        #1;
        rst_ni = 1;
        model_reset();
        irq_ack = 1; ack_id = 5'd11;
        step(); step();
        irq_ack = 0;
        n_cmp++;
        if (irq_valid !== 1'b0 || time_o !== 16'd2) begin
            n_err++;
            $display("FAIL areset_late_ack: valid=%0b time=%0d, want 0/2", irq_valid, time_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_two_lines();
        test_preempt();
        test_tie_and_reedge();
        test_disable();
        test_miss();
        test_random();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
